// File: rtl/cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder
//
// Adds two WIDTH-bit operands (plus a carry-in) by passing them one nibble
// per cycle through a single 4-bit carry-lookahead slice, LSB nibble first.
// The slice carry is registered between nibbles. The nibble sums build up in
// a partial-sum register, and the block-propagate bits are ANDed into p_all.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request an addition (accepted in IDLE or DONE)
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   c_in   in   1      carry into nibble 0, captured on the accepted start edge
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse when sum/c_out/p_all are updated
//   sum    out  WIDTH  result, held until the next done
//   c_out  out  1      carry out of the top nibble
//   p_all  out  1      AND of every nibble's block propagate
// ---------------------------------------------------------------------------
module cla_nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             p_all
);

   localparam int NIB = WIDTH / 4;
   // A one-nibble adder still needs a 1-bit counter.
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // 4-bit carry-lookahead slice: returns {block_p, carry_out, sum[3:0]}.
   // The block generate is not needed here because the carry comes from the
   // slice carry out directly.
   function automatic logic [5:0] cla4(input logic [3:0] x,
                                       input logic [3:0] y,
                                       input logic       ci);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      p    = x ^ y;
      g    = x & y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
      return {&p, c[4], p ^ c[3:0]};
   endfunction

   logic [1:0]       state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] psum_r;
   logic             pacc_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             c_out_r;
   logic             p_all_r;

   logic             accept_s;
   logic [5:0]       slice_s;
   logic [3:0]       slice_sum_s;
   logic             slice_c_s;
   logic             slice_p_s;
   logic [WIDTH-1:0] psum_next_s;

   // Slice evaluation, start qualification and partial-sum shift.
   always_comb begin
      accept_s    = 1'b0;
      slice_s     = cla4(a_r[3:0], b_r[3:0], carry_r);
      slice_sum_s = slice_s[3:0];
      slice_c_s   = slice_s[4];
      slice_p_s   = slice_s[5];
      // The new nibble enters at the top; after NIB shifts nibble 0 is at the bottom.
      psum_next_s = (psum_r >> 3'd4) | (WIDTH'(slice_sum_s) << (WIDTH - 4));
      if ((state_r == IDLE) || (state_r == DONE)) begin
         accept_s = start;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
         psum_r  <= '0;
         pacc_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sum_r   <= '0;
         c_out_r <= 1'b0;
         p_all_r <= 1'b0;
      end else if (accept_s) begin
         state_r <= BUSY;
         a_r     <= a;
         b_r     <= b;
         carry_r <= c_in;
         cnt_r   <= '0;
         psum_r  <= '0;
         pacc_r  <= 1'b1;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            BUSY: begin
               psum_r  <= psum_next_s;
               carry_r <= slice_c_s;
               pacc_r  <= pacc_r & slice_p_s;
               a_r     <= a_r >> 3'd4;
               b_r     <= b_r >> 3'd4;
               cnt_r   <= cnt_r + 1'b1;
               if (cnt_r == LAST_NIB) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  sum_r   <= psum_next_s;
                  c_out_r <= slice_c_s;
                  p_all_r <= pacc_r & slice_p_s;
               end else begin
                  done_r  <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            IDLE: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign sum   = sum_r;
   assign c_out = c_out_r;
   assign p_all = p_all_r;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_nibble_serial_adder
//
// Directed bench for cla_nibble_serial_adder (WIDTH=16). Stimulus pushes the
// hand-computed {sum, c_out, p_all} into a queue; an independent monitor pops
// and compares on every done pulse, and also checks that the outputs hold
// their value outside done and reset.
// ---------------------------------------------------------------------------
module tb_cla_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             c_in = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             p_all;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic rst_q = 1'b1;
   logic [17:0] exp_q[$];

   cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out),
      .p_all (p_all)
   );

   always #5 clk = ~clk;

   // cycle counter and the reset value seen by the DUT on each edge
   initial begin
      forever begin
         @(posedge clk);
         cyc   = cyc + 1;
         rst_q = rst;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // scoreboard monitor
   initial begin
      logic [17:0] prev;
      logic [17:0] exp;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            prev = '0;
         end else if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp = exp_q.pop_front();
               chk("result_sum",   {16'd0, sum}, {16'd0, exp[17:2]});
               chk("result_c_out", {31'd0, c_out}, {31'd0, exp[1]});
               chk("result_p_all", {31'd0, p_all}, {31'd0, exp[0]});
            end
            prev = {sum, c_out, p_all};
         end else begin
            chk("outputs_hold", {14'd0, sum, c_out, p_all}, {14'd0, prev});
         end
      end
   end

   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [15:0] es, input logic ec, input logic ep);
      int busy_cnt;
      int k;
      @(negedge clk);
      a = va; b = vb; c_in = vc; start = 1'b1;
      exp_q.push_back({es, ec, ep});
      @(negedge clk);
      start = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1;
      busy_cnt = 0;
      k = 0;
      while (!done && k < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         k++;
      end
      chk("busy_cycles", busy_cnt, NIB);
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int ndone;
      int k;
      int t1;
      int t2;

      repeat (3) @(negedge clk);
      chk("reset_state", {12'd0, busy, done, sum, c_out, p_all}, 32'd0);
      rst = 1'b0;

      run_op(16'h0606, 16'h0606, 1'b0, 16'h0C0C, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1);
      run_op(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

      // start pulsed during BUSY cycle 2 must be ignored
      @(negedge clk);
      a = 16'hFC0C; b = 16'hFF0F; c_in = 1'b0; start = 1'b1;
      exp_q.push_back({16'hFB1B, 1'b1, 1'b0});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("ignored_start_done_count", ndone, 1);

      // reset in BUSY cycle 2 aborts the operation
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_state", {12'd0, busy, done, sum, c_out, p_all}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", ndone, 0);

      // back-to-back with start held high
      @(negedge clk);
      a = 16'h0001; b = 16'h0000; c_in = 1'b1; start = 1'b1;
      exp_q.push_back({16'h0002, 1'b0, 1'b0});
      exp_q.push_back({16'h8000, 1'b0, 1'b0});
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_first_done", {31'd0, done}, 32'd1);
      t1 = cyc;
      a = 16'h7FFF; b = 16'h0001; c_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_second_done", {31'd0, done}, 32'd1);
      t2 = cyc;
      chk("b2b_spacing", t2 - t1, 5);

      repeat (10) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cla_nibble_serial_adder.md
# cla_nibble_serial_adder

Sequential front-end that drives the team's 4-bit carry-lookahead slice, the 4-bit CLA with block propagate/generate outputs. It accepts WIDTH-bit operands with a start pulse and feeds them through a single 4-bit CLA slice one nibble per cycle, LSB nibble first. The slice's carry is registered between nibbles, and the slice's sum and block propagate are collected into a WIDTH-bit result. This trades latency for area relative to a full-width CLA tree, and serves as the multi-nibble adder for the datapath.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibbles.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepted start edge only.
- b  input  WIDTH  operand B; sampled on the accepted start edge only.
- c_in  input  1  carry into nibble 0; sampled on the accepted start edge only.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; holds its value until the next done.
- c_out  output  1  carry out of the top nibble.
- p_all  output  1  AND of all nibble block-propagate signals; means the result equals a carry-chain pass-through.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE + start:
  - Latch a, b and c_in into operand shift registers and the carry register.
  - Clear the nibble counter and the partial-sum register.
  - Set the p_all accumulator to 1.
  - Go to BUSY.
- BUSY: each cycle, present the low nibble of the A and B shift registers plus the carry register to the 4-bit CLA slice. On the edge:
  - Shift the slice sum into the top of the partial-sum register, so nibbles land LSB-first after NIB shifts.
  - Load the carry register with the slice carry out.
  - AND the slice P into the p_all accumulator.
  - Shift both operand registers right by 4.
  - Increment the counter.
- BUSY exit: on the edge that processes nibble NIB-1:
  - Copy the partial-sum register (including that nibble) to sum.
  - Copy the final carry to c_out and the accumulator to p_all.
  - Go to DONE.
- DONE: done=1 for exactly this cycle.
  - If start=1, it is accepted as in IDLE, giving a back-to-back operation, and the next state is BUSY.
  - Otherwise the next state is IDLE.
- start in BUSY is ignored: no latch, no effect on the running operation.
- Arithmetic is unsigned modulo 2^WIDTH. {c_out, sum} = a + b + c_in exactly. No overflow flag.
- The slice G output is not used for result formation; carry comes from the slice c_out.
- Nibble counter width is clog2(NIB); it must not wrap before NIB-1 is reached. For WIDTH=4 the block takes one BUSY cycle.

## Timing
- Reset (rst=1 on an edge): state IDLE, busy=0, done=0, sum=0, c_out=0, p_all=0. Counter, carry and shift registers are cleared.
- Reset in BUSY or DONE aborts the operation; no done pulse is produced for it. Reset has priority over start.
- Start accepted at edge T0. busy=1 from after T0 through edge T(NIB). Edge T(NIB) moves busy to 0 and done to 1 in the same cycle.
- Latency: done is high in the cycle after edge T(NIB). For WIDTH=16 that is the cycle after the 4th edge following start.
- sum, c_out and p_all change only on the edge that asserts done, or on reset. They are stable during BUSY and IDLE.
- Throughput: one result per NIB+1 cycles with start held high. With start asserted in every DONE cycle, back-to-back results come every NIB+1 cycles.
- Operand inputs may change freely after the accepted start edge.

## Test plan
- Basic add: reset, then start with a=0x0606, b=0x0606, c_in=0.
  - busy high for 4 cycles.
  - Then done pulse with sum=0x0C0C, c_out=0, p_all=0.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, p_all=0 (nibble 0 P=0).
- All-propagate: a=0xAAAA, b=0x5555, c_in=1 -> sum=0x0000, c_out=1, p_all=1. Same operands with c_in=0 -> sum=0xFFFF, c_out=0, p_all=1.
- start ignored while busy:
  - Start a=0xFC0C, b=0xFF0F, c_in=0.
  - Pulse start with different operands in BUSY cycle 2.
  - Exactly one done, sum=0xFB1B, c_out=1.
  - No second done follows.
- Reset mid-operation: start a=0x1234, b=0x1111, then rst=1 in BUSY cycle 2.
  - Next cycle: IDLE, busy=0, done=0, sum=0, c_out=0, p_all=0.
  - No done ever appears for the aborted operation.
- Back-to-back: hold start=1 with a=0x0001, b=0x0000, c_in=1, then a=0x7FFF, b=0x0001, c_in=0 presented in the DONE cycle.
  - Two done pulses exactly 5 cycles apart.
  - First: sum=0x0002, c_out=0.
  - Second: sum=0x8000, c_out=0.
